// File: rtl/sys_cmd_master.sv
// ---------------------------------------------------------------------------
// sys_cmd_master
//   Host-side initiator for the UART register/ALU command protocol.
//   It takes one command and sends it as a frame, one byte per tx handshake.
//   It then collects the response bytes from the UART receiver and returns
//   one result word, with error and timeout flags.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   cmd_*           command request (valid/ready) and its fields
//   tx_byte/valid   frame byte towards the UART transmitter
//   tx_ready        transmitter can accept a byte
//   rx_*            response byte strobe from the UART receiver, with its
//                   parity and stop-bit error flags
//   rsp_valid       one-cycle completion pulse
//   rsp_data        result word (RD: {00,byte}; ALU: {byte1,byte0}; WR: 0)
//   rsp_err         a parity or stop error was seen on a response byte
//   rsp_timeout     the response timed out
//   busy            the master is not idle
// ---------------------------------------------------------------------------
module sys_cmd_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_type,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [DATA_WIDTH-1:0]    cmd_op_a,
    input  logic [DATA_WIDTH-1:0]    cmd_op_b,
    input  logic [ALU_FUN_WIDTH-1:0] cmd_alu_fun,
    output logic [DATA_WIDTH-1:0]    tx_byte,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [DATA_WIDTH-1:0]    rx_byte,
    input  logic                     rx_valid,
    input  logic                     rx_par_err,
    input  logic                     rx_stp_err,
    output logic                     rsp_valid,
    output logic [ALU_OUT_WIDTH-1:0] rsp_data,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    output logic                     busy
);

    localparam int TCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DATA_WIDTH-1:0] HDR_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] HDR_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] HDR_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] HDR_NOP = DATA_WIDTH'(8'hDD);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0]    frame_q [4];
    logic [DATA_WIDTH-1:0]    frame_d [4];
    logic [2:0]               flen_q, flen_d;
    logic [1:0]               nexp_q, nexp_d;
    logic [1:0]               idx_q;
    logic [1:0]               rcnt_q;
    logic [TCNT_W-1:0]        tcnt_q;
    logic [ALU_OUT_WIDTH-1:0] rsp_data_q;
    logic                     rsp_err_q;
    logic                     rsp_timeout_q;

    logic accept, tx_fire, tx_last, rx_take, rx_last, tmo_hit;

    function automatic logic [DATA_WIDTH-1:0] zext_addr(input logic [ADDR_WIDTH-1:0] a);
        zext_addr = '0;
        zext_addr[ADDR_WIDTH-1:0] = a;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] zext_fun(input logic [ALU_FUN_WIDTH-1:0] f);
        zext_fun = '0;
        zext_fun[ALU_FUN_WIDTH-1:0] = f;
    endfunction

    // Frame image built from the live command fields; latched on acceptance.
    always_comb begin
        frame_d[0] = HDR_WR;
        frame_d[1] = '0;
        frame_d[2] = '0;
        frame_d[3] = '0;
        flen_d     = 3'd3;
        nexp_d     = 2'd0;
        case (cmd_type)
            2'd0: begin
                frame_d[0] = HDR_WR;
                frame_d[1] = zext_addr(cmd_addr);
                frame_d[2] = cmd_wdata;
                flen_d     = 3'd3;
                nexp_d     = 2'd0;
            end
            2'd1: begin
                frame_d[0] = HDR_RD;
                frame_d[1] = zext_addr(cmd_addr);
                flen_d     = 3'd2;
                nexp_d     = 2'd1;
            end
            2'd2: begin
                frame_d[0] = HDR_ALU;
                frame_d[1] = cmd_op_a;
                frame_d[2] = cmd_op_b;
                frame_d[3] = zext_fun(cmd_alu_fun);
                flen_d     = 3'd4;
                nexp_d     = 2'd2;
            end
            default: begin
                frame_d[0] = HDR_NOP;
                frame_d[1] = zext_fun(cmd_alu_fun);
                flen_d     = 3'd2;
                nexp_d     = 2'd2;
            end
        endcase
    end

    // cmd_ready is held low while reset is asserted so every output reads 0
    // during reset; it rises in the first cycle with RST low.
    assign cmd_ready = (state == S_IDLE) && !RST;
    assign accept    = cmd_valid && cmd_ready;
    assign tx_fire   = (state == S_SEND) && tx_ready;
    assign tx_last   = tx_fire && ({1'b0, idx_q} == (flen_q - 3'd1));
    assign rx_take   = (state == S_WAIT_RSP) && rx_valid;
    assign rx_last   = rx_take && ((rcnt_q + 2'd1) == nexp_q);
    // The counter would reach TIMEOUT_CYCLES-1 at this edge; a byte in the
    // same cycle takes priority.
    assign tmo_hit   = (state == S_WAIT_RSP) && !rx_valid
                       && (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 2));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_SEND;
            S_SEND:     if (tx_last) state_nxt = (nexp_q == 2'd0) ? S_DONE : S_WAIT_RSP;
            S_WAIT_RSP: if (rx_last || tmo_hit) state_nxt = S_DONE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Control and result state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_IDLE;
            flen_q        <= 3'd0;
            nexp_q        <= 2'd0;
            idx_q         <= 2'd0;
            rcnt_q        <= 2'd0;
            tcnt_q        <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                flen_q        <= flen_d;
                nexp_q        <= nexp_d;
                idx_q         <= 2'd0;
                rcnt_q        <= 2'd0;
                tcnt_q        <= '0;
                rsp_data_q    <= '0;
                rsp_err_q     <= 1'b0;
                rsp_timeout_q <= 1'b0;
            end
            if (tx_fire) begin
                idx_q <= idx_q + 2'd1;
            end
            if (tx_last) begin
                tcnt_q <= '0;
            end
            if (rx_take) begin
                rcnt_q <= rcnt_q + 2'd1;
                tcnt_q <= '0;
                if (rcnt_q == 2'd0) begin
                    rsp_data_q[DATA_WIDTH-1:0] <= rx_byte;
                end else begin
                    rsp_data_q[2*DATA_WIDTH-1:DATA_WIDTH] <= rx_byte;
                end
                if (rx_par_err || rx_stp_err) begin
                    rsp_err_q <= 1'b1;
                end
            end else if (state == S_WAIT_RSP) begin
                tcnt_q <= tcnt_q + 1'b1;
            end
            if (tmo_hit) begin
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    // Frame bytes are plain data; they are only observed while in SEND.
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                frame_q[i] <= frame_d[i];
            end
        end
    end

    assign tx_valid    = (state == S_SEND);
    assign tx_byte     = (state == S_SEND) ? frame_q[idx_q] : '0;
    assign rsp_valid   = (state == S_DONE);
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_sys_cmd_master.sv
module tb_sys_cmd_master;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int FW  = 4;
    localparam int OW  = 16;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_type;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] cmd_op_a;
    logic [DW-1:0] cmd_op_b;
    logic [FW-1:0] cmd_alu_fun;
    logic [DW-1:0] tx_byte;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_byte;
    logic          rx_valid;
    logic          rx_par_err;
    logic          rx_stp_err;
    logic          rsp_valid;
    logic [OW-1:0] rsp_data;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    sys_cmd_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_FUN_WIDTH(FW),
        .ALU_OUT_WIDTH(OW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(clk), .RST(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_op_a(cmd_op_a),
        .cmd_op_b(cmd_op_b), .cmd_alu_fun(cmd_alu_fun),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_par_err(rx_par_err),
        .rx_stp_err(rx_stp_err),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command, end to end. nrep < expected count means the responder
    // goes silent and the command must time out. gN = idle cycles before
    // reply byte N. txmode: 0 ready always, 1 toggling, 2 random.
    task automatic run_cmd(input string nm, input logic [1:0] typ, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [FW-1:0] fun,
                           input int txmode, input int nrep,
                           input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                           input logic e0, input logic e1, input int g0, input int g1);
        logic [DW-1:0] ef[$];
        logic [DW-1:0] got[$];
        logic [DW-1:0] rep[2];
        logic          erf[2];
        int            gap[2];
        int            nexp, cyc, last_ev, rv_cyc, rcvd, w;
        logic          prev_stall, exp_err, exp_tmo;
        logic [DW-1:0] prev_byte;
        logic [OW-1:0] exp_data;

        rep[0] = r0; rep[1] = r1; erf[0] = e0; erf[1] = e1; gap[0] = g0; gap[1] = g1;
        case (typ)
            2'd0: begin ef = '{8'hAA, DW'(addr), wdata};           nexp = 0; end
            2'd1: begin ef = '{8'hBB, DW'(addr)};                  nexp = 1; end
            2'd2: begin ef = '{8'hCC, a, b, DW'(fun)};             nexp = 2; end
            default: begin ef = '{8'hDD, DW'(fun)};                nexp = 2; end
        endcase
        if (nrep > nexp) nrep = nexp;
        exp_tmo  = (nrep < nexp);
        exp_data = '0;
        exp_err  = 1'b0;
        for (int i = 0; i < nrep; i++) begin
            exp_data[i*DW +: DW] = rep[i];
            exp_err = exp_err | erf[i];
        end

        @(negedge clk);
        cmd_type = typ; cmd_addr = addr; cmd_wdata = wdata;
        cmd_op_a = a; cmd_op_b = b; cmd_alu_fun = fun; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " cmd_ready"}, cmd_ready, 1'b1);

        cyc = 0; last_ev = 0; rv_cyc = -1; rcvd = 0; prev_stall = 1'b0; prev_byte = '0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0;
            // Scramble the inputs: the frame must come from the latched copy.
            cmd_type = 2'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
            cmd_op_a = DW'($urandom); cmd_op_b = DW'($urandom); cmd_alu_fun = FW'($urandom);
            rx_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
            if (cyc == 1) chk({nm, " tx_valid cycle1"}, tx_valid, 1'b1);
            if (rsp_valid) begin
                rv_cyc = cyc;
                break;
            end
            if (got.size() < ef.size()) begin
                case (txmode)
                    0:       tx_ready = 1'b1;
                    1:       tx_ready = cyc[0];
                    default: tx_ready = 1'($urandom);
                endcase
                if (prev_stall) begin
                    chk({nm, " stall valid"}, tx_valid, 1'b1);
                    chk({nm, " stall byte"}, tx_byte, prev_byte);
                end
                if (tx_valid && tx_ready) begin
                    got.push_back(tx_byte);
                    if (got.size() == ef.size()) last_ev = cyc;
                end
                prev_stall = tx_valid && !tx_ready;
                prev_byte  = tx_byte;
                // Stray receive strobes while sending must be ignored.
                if ($urandom_range(3) == 0) begin
                    rx_valid = 1'b1; rx_byte = DW'($urandom);
                    rx_par_err = 1'($urandom); rx_stp_err = 1'($urandom);
                end
            end else begin
                tx_ready = 1'($urandom);
                if (rcvd < nrep && (cyc - last_ev - 1) == gap[rcvd]) begin
                    rx_valid = 1'b1; rx_byte = rep[rcvd];
                    rx_par_err = erf[rcvd] & cyc[0];
                    rx_stp_err = erf[rcvd] & ~cyc[0];
                    rcvd++;
                    last_ev = cyc;
                end
            end
        end
        chk({nm, " completed in bound"}, rv_cyc > 0, 1'b1);
        chk({nm, " frame length"}, got.size(), ef.size());
        for (int i = 0; i < ef.size() && i < got.size(); i++)
            chk($sformatf("%s tx byte %0d", nm, i), got[i], ef[i]);
        chk({nm, " rsp latency"}, rv_cyc - last_ev, exp_tmo ? TMO : 1);
        chk({nm, " rsp_data"}, rsp_data, exp_data);
        chk({nm, " rsp_err"}, rsp_err, exp_err);
        chk({nm, " rsp_timeout"}, rsp_timeout, exp_tmo);
        chk({nm, " busy in done"}, busy, 1'b1);
        // Stray strobe in DONE, then in IDLE: results must hold.
        rx_valid = 1'b1; rx_byte = 8'hE7; rx_par_err = 1'b1; rx_stp_err = 1'b1;
        @(negedge clk);
        chk({nm, " rsp_valid one cycle"}, rsp_valid, 1'b0);
        chk({nm, " busy after"}, busy, 1'b0);
        chk({nm, " cmd_ready after"}, cmd_ready, 1'b1);
        @(negedge clk);
        rx_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
        chk({nm, " rsp_data hold"}, {rsp_data, rsp_err, rsp_timeout}, {exp_data, exp_err, exp_tmo});
        chk({nm, " idle after stray"}, {busy, tx_valid, rsp_valid}, 3'b000);
    endtask

    task automatic reset_mid_frame();
        int w;
        @(negedge clk);
        cmd_type = 2'd0; cmd_addr = 4'h7; cmd_wdata = 8'h99; cmd_valid = 1'b1; tx_ready = 1'b1;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rstmid byte0", tx_byte, 8'hAA);
        @(negedge clk);
        chk("rstmid byte1", tx_byte, 8'h07);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid outputs", {tx_valid, busy, rsp_valid, cmd_ready}, 4'b0000);
        chk("rstmid rsp_data", rsp_data, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid quiet %0d", i), {rsp_valid, busy, cmd_ready}, 3'b001);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_addr = '0; cmd_wdata = '0;
        cmd_op_a = '0; cmd_op_b = '0; cmd_alu_fun = '0; tx_ready = 1'b0;
        rx_byte = '0; rx_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {cmd_ready, tx_valid, rsp_valid, rsp_err, rsp_timeout, busy}, 6'b0);
        chk("reset tx_byte", tx_byte, 8'h00);
        chk("reset rsp_data", rsp_data, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready after reset", cmd_ready, 1'b1);

        run_cmd("t1 WR", 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        run_cmd("t2 RD", 2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1, 8'h5A, 8'h00, 0, 0, 3, 0);
        run_cmd("t3 ALU", 2'd2, 4'h0, 8'h00, 8'h10, 8'h20, 4'h1, 1, 2, 8'h34, 8'h12, 0, 0, 2, 5);
        run_cmd("t4 RD tmo", 2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        run_cmd("t5 NOP err", 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 2, 2, 8'h34, 8'h00, 1, 0, 1, 1);
        run_cmd("edge gap", 2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1, 8'hC3, 8'h00, 0, 0, TMO-2, 0);
        run_cmd("partial tmo", 2'd2, 4'h0, 8'h00, 8'hFF, 8'h01, 4'hF, 2, 1, 8'h77, 8'h00, 1, 0, TMO-2, 0);
        reset_mid_frame();
        run_cmd("t6 WR after rst", 2'd0, 4'hF, 8'hA5, 8'h00, 8'h00, 4'h0, 2, 0, 8'h00, 8'h00, 0, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            logic [1:0] typ;
            int         nexp, nrep;
            typ  = 2'($urandom);
            nexp = (typ == 2'd0) ? 0 : (typ == 2'd1) ? 1 : 2;
            nrep = nexp;
            if (nexp > 0 && $urandom_range(5) == 0) nrep = $urandom_range(nexp - 1);
            run_cmd($sformatf("rnd%0d", k), typ, AW'($urandom), DW'($urandom), DW'($urandom),
                    DW'($urandom), FW'($urandom), $urandom_range(2), nrep,
                    DW'($urandom), DW'($urandom), ($urandom_range(7) == 0), ($urandom_range(7) == 0),
                    $urandom_range(TMO-2), $urandom_range(TMO-2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
